wb_arbiter_2m: RTL and testbench



---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_arbiter_2m_if.sv | 27 ++
 rtl/wb_arbiter_2m_watchdog.sv | 42 ++++
 rtl/wb_arbiter_2m.sv | 131 +++++++++++++
 tb/tb_wb_arbiter_2m.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and default widths for the two-master Wishbone arbiter.
package wb_pkg;

  localparam int WB_ADR_WIDTH = 23;
  localparam int WB_DAT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [WB_ADR_WIDTH-1:0] adr;
    logic [WB_DAT_WIDTH-1:0] dat;
  } wb_m2s_t;

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone classic point-to-point bundle; dat_w flows master->slave, dat_r slave->master.
interface wb_arbiter_2m_if import wb_pkg::*; #(
  parameter int ADR_WIDTH = WB_ADR_WIDTH,
  parameter int DAT_WIDTH = WB_DAT_WIDTH
) ();

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [ADR_WIDTH-1:0] adr;
  logic [DAT_WIDTH-1:0] dat_w;
  logic [DAT_WIDTH-1:0] dat_r;
  logic                 ack;
  logic                 err;
  logic                 rty;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack, err, rty
  );

endinterface

// File: rtl/wb_arbiter_2m_watchdog.sv
// Stall watchdog: counts unterminated strobed cycles and raises a sticky abort at the limit.
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic busy,
  input  logic term,
  input  logic state_chg,
  output logic timeout,
  output logic abort
);

  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q;
  logic            abort_q;

  assign timeout = (cnt_q == Limit);
  assign abort   = abort_q | timeout;

  // The timeout cycle itself clears the counter so err is a single-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      if (term || state_chg || timeout) begin
        cnt_q <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_chg) begin
        abort_q <= 1'b0;
      end else if (timeout) begin
        abort_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Round-robin arbiter giving two Wishbone masters a shared slave with zero-dead-cycle handover.
// Optional stall watchdog is compiled in with `define WB_ARB_WATCHDOG_EN.
module wb_arbiter_2m import wb_pkg::*; #(
  parameter int ADR_WIDTH      = WB_ADR_WIDTH,
  parameter int DAT_WIDTH      = WB_DAT_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  wb_arbiter_2m_if.slave         m0,
  wb_arbiter_2m_if.slave         m1,
  wb_arbiter_2m_if.master        s,
  output logic [1:0]             gnt_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t state_q, state_d;
  logic       last_q;

  logic                 sel_cyc;
  logic                 sel_stb;
  logic                 sel_we;
  logic [ADR_WIDTH-1:0] sel_adr;
  logic [DAT_WIDTH-1:0] sel_dat;

  logic abort;
  logic wd_timeout;

  // last_q tracks the most recent owner so a tie from idle goes to the other master.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == ST_GNT0) begin
        last_q <= 1'b0;
      end else if (state_d == ST_GNT1) begin
        last_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_o   = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
        end else if (m0.cyc) begin
          state_d = ST_GNT0;
        end else if (m1.cyc) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        gnt_o = 2'b01;
        if (!m0.cyc) begin
          state_d = m1.cyc ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        gnt_o = 2'b10;
        if (!m1.cyc) begin
          state_d = m0.cyc ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    if (gnt_o[0]) begin
      sel_cyc = m0.cyc;
      sel_stb = m0.stb;
      sel_we  = m0.we;
      sel_adr = m0.adr;
      sel_dat = m0.dat_w;
    end else if (gnt_o[1]) begin
      sel_cyc = m1.cyc;
      sel_stb = m1.stb;
      sel_we  = m1.we;
      sel_adr = m1.adr;
      sel_dat = m1.dat_w;
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .busy     (s.cyc & s.stb),
    .term     (s.ack | s.err | s.rty),
    .state_chg(state_d != state_q),
    .timeout  (wd_timeout),
    .abort    (abort)
  );
`else
  assign wd_timeout = 1'b0;
  assign abort      = 1'b0;
`endif

  assign s.cyc   = sel_cyc & ~abort;
  assign s.stb   = sel_stb & ~abort;
  assign s.we    = sel_we;
  assign s.adr   = sel_adr;
  assign s.dat_w = sel_dat;

  // Read data is broadcast; terminations reach only the current owner.
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

  assign m0.ack = gnt_o[0] & s.ack & ~abort;
  assign m0.err = gnt_o[0] & (s.err | wd_timeout);
  assign m0.rty = gnt_o[0] & s.rty;
  assign m1.ack = gnt_o[1] & s.ack & ~abort;
  assign m1.err = gnt_o[1] & (s.err | wd_timeout);
  assign m1.rty = gnt_o[1] & s.rty;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed vector table, corner sequences, randomized run vs model.
module tb_wb_arbiter_2m;
  import wb_pkg::*;

  localparam int AW      = WB_ADR_WIDTH;
  localparam int DW      = WB_DAT_WIDTH;
  localparam int TIMEOUT = 8;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] gnt_o;

  wb_arbiter_2m_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) m0_bus ();
  wb_arbiter_2m_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) m1_bus ();
  wb_arbiter_2m_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) s_bus ();

  wb_arbiter_2m #(
    .ADR_WIDTH     (AW),
    .DAT_WIDTH     (DW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .gnt_o (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    wb_m2s_t       m0;
    wb_m2s_t       m1;
    logic          ack;
    logic [DW-1:0] sdat;
    logic [1:0]    gnt;
    wb_m2s_t       s;
    logic [1:0]    acks;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t vecs[$];

  // Current stimulus, kept for the reference model
  wb_m2s_t       cur_a, cur_b;
  logic          cur_ack, cur_err, cur_rty;
  logic [DW-1:0] cur_sdat;

  // Reference model: who owns the slave, who owned it last, stall count, abort flag
  int m_own, m_last, m_cnt;
  bit m_abort;

  function automatic wb_m2s_t req(input logic c, input logic st, input logic w,
                                  input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {c, st, w, a, d};
  endfunction

  function automatic vec_t mkVec(input wb_m2s_t a, input wb_m2s_t b, input logic ack,
                                 input logic [DW-1:0] sdat, input logic [1:0] gnt,
                                 input wb_m2s_t es, input logic [1:0] eacks,
                                 input logic [DW-1:0] erdat);
    vec_t v;
    v.m0 = a; v.m1 = b; v.ack = ack; v.sdat = sdat;
    v.gnt = gnt; v.s = es; v.acks = eacks; v.rdat = erdat;
    return v;
  endfunction

  function automatic wb_m2s_t slaveSide();
    return {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.dat_w};
  endfunction

  function automatic logic [5:0] allTerms();
    return {m1_bus.ack, m1_bus.err, m1_bus.rty, m0_bus.ack, m0_bus.err, m0_bus.rty};
  endfunction

  task automatic applyStimulus(input wb_m2s_t a, input wb_m2s_t b, input logic ack,
                               input logic err, input logic rty, input logic [DW-1:0] sdat);
    cur_a = a; cur_b = b; cur_ack = ack; cur_err = err; cur_rty = rty; cur_sdat = sdat;
    m0_bus.cyc = a.cyc; m0_bus.stb = a.stb; m0_bus.we = a.we;
    m0_bus.adr = a.adr; m0_bus.dat_w = a.dat;
    m1_bus.cyc = b.cyc; m1_bus.stb = b.stb; m1_bus.we = b.we;
    m1_bus.adr = b.adr; m1_bus.dat_w = b.dat;
    s_bus.ack = ack; s_bus.err = err; s_bus.rty = rty; s_bus.dat_r = sdat;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic modelReset();
    m_own = -1; m_last = 1; m_cnt = 0; m_abort = 1'b0;
  endtask

  // Round robin among the masters currently requesting; ties go away from the last owner.
  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic checkModelAndStep();
    bit         tmo, abrt;
    wb_m2s_t    own, exp_s;
    logic [2:0] t, exp_t0, exp_t1;
    logic [1:0] exp_g;
    int         new_own;
`ifdef WB_ARB_WATCHDOG_EN
    tmo = (m_cnt == TIMEOUT);
`else
    tmo = 1'b0;
`endif
    abrt   = m_abort | tmo;
    own    = (m_own == 0) ? cur_a : cur_b;
    exp_s  = '0;
    exp_t0 = '0;
    exp_t1 = '0;
    exp_g  = 2'b00;
    if (m_own >= 0) begin
      exp_s     = own;
      exp_s.cyc = own.cyc & ~abrt;
      exp_s.stb = own.stb & ~abrt;
      t = {cur_ack & ~abrt, cur_err | tmo, cur_rty};
      if (m_own == 0) begin exp_t0 = t; exp_g = 2'b01; end
      else            begin exp_t1 = t; exp_g = 2'b10; end
    end
    checkOutput("rand_slave", 64'(slaveSide()), 64'(exp_s));
    checkOutput("rand_term", 64'(allTerms()), 64'({exp_t1, exp_t0}));
    checkOutput("rand_gnt_rdat", 64'({gnt_o, m1_bus.dat_r, m0_bus.dat_r}),
                64'({exp_g, cur_sdat, cur_sdat}));

    new_own = (m_own >= 0 && own.cyc) ? m_own : pick(cur_a.cyc, cur_b.cyc, m_last);
    if (new_own != m_own) begin
      m_cnt   = 0;
      m_abort = 1'b0;
      if (new_own >= 0) m_last = new_own;
    end else begin
      if (cur_ack || cur_err || cur_rty || tmo) m_cnt = 0;
      else if (exp_s.cyc && exp_s.stb) m_cnt++;
      if (tmo) m_abort = 1'b1;
    end
    m_own = new_own;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    wb_m2s_t no_req, ra, rb, rw, rr, rh, rq0, rq1;
    bit      c0, c1;

    no_req = '0;
    ra = req(1'b1, 1'b1, 1'b0, 23'h000010, 8'h00);
    rb = req(1'b1, 1'b1, 1'b1, 23'h000020, 8'h11);
    rw = req(1'b1, 1'b1, 1'b1, 23'h7FFFFF, 8'hC3);
    rr = req(1'b1, 1'b1, 1'b0, 23'h000123, 8'h00);
    rh = req(1'b1, 1'b0, 1'b0, 23'h000055, 8'h00);

    // Simultaneous requests from reset, then handover without an idle cycle
    vecs.push_back(mkVec(ra,     rb,     1'b0, 8'h00, 2'b00, no_req, 2'b00, 8'h00));
    vecs.push_back(mkVec(ra,     rb,     1'b1, 8'h00, 2'b01, ra,     2'b01, 8'h00));
    vecs.push_back(mkVec(no_req, rb,     1'b0, 8'h00, 2'b01, no_req, 2'b00, 8'h00));
    vecs.push_back(mkVec(no_req, rb,     1'b1, 8'h00, 2'b10, rb,     2'b10, 8'h00));
    vecs.push_back(mkVec(no_req, no_req, 1'b0, 8'h00, 2'b10, no_req, 2'b00, 8'h00));
    vecs.push_back(mkVec(no_req, no_req, 1'b0, 8'h00, 2'b00, no_req, 2'b00, 8'h00));
    // m1 write at the top of the address space; idle-time ack is dropped
    vecs.push_back(mkVec(no_req, rw,     1'b0, 8'h00, 2'b00, no_req, 2'b00, 8'h00));
    vecs.push_back(mkVec(no_req, rw,     1'b0, 8'h00, 2'b10, rw,     2'b00, 8'h00));
    vecs.push_back(mkVec(no_req, rw,     1'b1, 8'h00, 2'b10, rw,     2'b10, 8'h00));
    vecs.push_back(mkVec(no_req, no_req, 1'b0, 8'h00, 2'b10, no_req, 2'b00, 8'h00));
    vecs.push_back(mkVec(no_req, no_req, 1'b1, 8'h77, 2'b00, no_req, 2'b00, 8'h77));
    // m0 single read, ack two cycles after grant
    vecs.push_back(mkVec(rr,     no_req, 1'b0, 8'h00, 2'b00, no_req, 2'b00, 8'h00));
    vecs.push_back(mkVec(rr,     no_req, 1'b0, 8'h00, 2'b01, rr,     2'b00, 8'h00));
    vecs.push_back(mkVec(rr,     no_req, 1'b0, 8'h00, 2'b01, rr,     2'b00, 8'h00));
    vecs.push_back(mkVec(rr,     no_req, 1'b1, 8'h5A, 2'b01, rr,     2'b01, 8'h5A));
    vecs.push_back(mkVec(no_req, no_req, 1'b0, 8'h00, 2'b01, no_req, 2'b00, 8'h00));
    vecs.push_back(mkVec(no_req, no_req, 1'b0, 8'h00, 2'b00, no_req, 2'b00, 8'h00));
    // cyc held with stb low keeps the grant
    vecs.push_back(mkVec(rh,     no_req, 1'b0, 8'h00, 2'b00, no_req, 2'b00, 8'h00));
    vecs.push_back(mkVec(rh,     no_req, 1'b0, 8'h00, 2'b01, rh,     2'b00, 8'h00));
    vecs.push_back(mkVec(no_req, no_req, 1'b0, 8'h00, 2'b01, no_req, 2'b00, 8'h00));
    vecs.push_back(mkVec(no_req, no_req, 1'b0, 8'h00, 2'b00, no_req, 2'b00, 8'h00));

    $display("[TB] reset state");
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, '0);
    #2;
    checkOutput("reset_gnt", 64'(gnt_o), 64'(2'b00));
    checkOutput("reset_slave", 64'(slaveSide()), 64'(no_req));
    checkOutput("reset_terms", 64'(allTerms()), 64'(6'b0));

    $display("[TB] vector table");
    doReset();
    foreach (vecs[i]) begin
      @(negedge clk_i);
      applyStimulus(vecs[i].m0, vecs[i].m1, vecs[i].ack, 1'b0, 1'b0, vecs[i].sdat);
      #1;
      checkOutput($sformatf("vec%0d_gnt", i), 64'(gnt_o), 64'(vecs[i].gnt));
      checkOutput($sformatf("vec%0d_slave", i), 64'(slaveSide()), 64'(vecs[i].s));
      checkOutput($sformatf("vec%0d_ack", i), 64'({m1_bus.ack, m0_bus.ack}), 64'(vecs[i].acks));
      checkOutput($sformatf("vec%0d_rdat", i), 64'({m1_bus.dat_r, m0_bus.dat_r}),
                  64'({vecs[i].rdat, vecs[i].rdat}));
      checkOutput($sformatf("vec%0d_err_rty", i),
                  64'({m1_bus.err, m1_bus.rty, m0_bus.err, m0_bus.rty}), 64'(4'b0));
    end

    $display("[TB] round-robin fairness");
    doReset();
    applyStimulus(ra, rb, 1'b0, 1'b0, 1'b0, '0);
    for (int g = 0; g < 6; g++) begin
      @(negedge clk_i);
      applyStimulus(ra, rb, 1'b0, 1'b0, 1'b0, '0);
      #1;
      checkOutput($sformatf("rr_grant%0d", g), 64'({gnt_o, s_bus.cyc}),
                  64'({(g % 2 == 0) ? 2'b01 : 2'b10, 1'b1}));
      s_bus.ack = 1'b1;
      @(negedge clk_i);
      if (g % 2 == 0) applyStimulus(no_req, rb, 1'b0, 1'b0, 1'b0, '0);
      else            applyStimulus(ra, no_req, 1'b0, 1'b0, 1'b0, '0);
    end

`ifdef WB_ARB_WATCHDOG_EN
    $display("[TB] watchdog");
    doReset();
    rq0 = req(1'b1, 1'b1, 1'b0, 23'h000040, 8'h00);
    applyStimulus(rq0, no_req, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk_i);
      #1;
      checkOutput($sformatf("wd_stall%0d", i), 64'({m0_bus.err, s_bus.cyc}), 64'(2'b01));
    end
    @(negedge clk_i);
    #1;
    checkOutput("wd_timeout", 64'({m0_bus.err, s_bus.cyc, s_bus.stb}), 64'(3'b100));
    @(negedge clk_i);
    applyStimulus(rq0, no_req, 1'b1, 1'b0, 1'b0, 8'h33);
    #1;
    checkOutput("wd_late_ack", 64'({m0_bus.ack, m0_bus.err, s_bus.cyc, gnt_o}), 64'(5'b00001));
    @(negedge clk_i);
    applyStimulus(no_req, no_req, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    #1;
    checkOutput("wd_release", 64'(gnt_o), 64'(2'b00));
`else
    $display("[TB] stalled slave without watchdog");
    doReset();
    rq0 = req(1'b1, 1'b1, 1'b0, 23'h000040, 8'h00);
    applyStimulus(rq0, no_req, 1'b0, 1'b0, 1'b0, '0);
    repeat (3 * TIMEOUT) @(negedge clk_i);
    #1;
    checkOutput("no_watchdog", 64'({m0_bus.err, s_bus.cyc, s_bus.stb, gnt_o}), 64'(5'b01101));
`endif

    $display("[TB] reset mid-cycle");
    doReset();
    rq1 = req(1'b1, 1'b1, 1'b0, 23'h000099, 8'h00);
    applyStimulus(no_req, rq1, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    #1;
    checkOutput("rst_pre_gnt", 64'({gnt_o, s_bus.cyc}), 64'(3'b101));
    #2;
    rst_ni = 1'b0;
    s_bus.ack = 1'b1;
    #1;
    checkOutput("rst_async_gnt", 64'(gnt_o), 64'(2'b00));
    checkOutput("rst_async_slave", 64'(slaveSide()), 64'(no_req));
    checkOutput("rst_async_terms", 64'(allTerms()), 64'(6'b0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(ra, rb, 1'b0, 1'b0, 1'b0, '0);
    #1;
    checkOutput("rst_release_idle", 64'(gnt_o), 64'(2'b00));
    @(negedge clk_i);
    #1;
    checkOutput("rst_first_m0", 64'(gnt_o), 64'(2'b01));

    $display("[TB] randomized run");
    doReset();
    modelReset();
    c0 = 1'b0;
    c1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_i);
      if ($urandom_range(3) == 0) c0 = ~c0;
      if ($urandom_range(3) == 0) c1 = ~c1;
      rq0 = req(c0, $urandom_range(3) != 0, 1'($urandom), AW'($urandom), DW'($urandom));
      rq1 = req(c1, $urandom_range(3) != 0, 1'($urandom), AW'($urandom), DW'($urandom));
      applyStimulus(rq0, rq1, $urandom_range(3) == 0, $urandom_range(15) == 0,
                    $urandom_range(15) == 0, DW'($urandom));
      #1;
      checkModelAndStep();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
